// File: rtl/rx_iq_packer_if.sv
// Sample/word stream bundle for rx_iq_packer: NCH-wide I/Q capture side and
// the 32-bit FWFT output side. slave = packer view, master = environment view.
interface rx_iq_packer_if #(
    parameter int NCH = 2,
    parameter int SW  = 12
) ();
    logic                in_valid;
    logic [NCH*SW-1:0]   in_i;
    logic [NCH*SW-1:0]   in_q;
    logic [31:0]         out_data;
    logic [1:0]          out_chan;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  out_data, out_chan, out_valid
    );

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rx_iq_packer.sv
// Multi-channel AD9361 receive packer: sign-extends I/Q pairs into 32-bit words,
// serialises enabled channels into an FWFT FIFO. Optional TDD window: RX_PACK_TDD_GATE_EN.
module rx_iq_packer #(
    parameter int NCH   = 2,
    parameter int SW    = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NCH-1:0]           chan_mask_i,
    input  logic                     sync_i,
    rx_iq_packer_if.slave            stream,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [15:0]              ovf_cnt_o,
    input  logic                     ovf_clr_i,
    input  logic [23:0]              frame_len_i,
    input  logic [23:0]              rstart_i,
    input  logic [23:0]              rend_i,
    output logic                     tdd_open_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e              state_q, state_d;
    logic [NCH-1:0]      rem_q, rem_d;
    logic [NCH*SW-1:0]   hold_i_q, hold_i_d, hold_q_q, hold_q_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [LW-1:0]       wr_q, wr_d, rd_q, rd_d, level;
    logic [33:0]         mem_q [DEPTH];

    logic                gate, accept, take, drop, push, pop, full, last_wr, sel_found;
    logic [1:0]          cur_ch;
    logic [SW-1:0]       cur_i, cur_q;
    logic [31:0]         word;

    // Lowest still-pending channel of the held set.
    always_comb begin
        sel_found = 1'b0;
        cur_ch    = '0;
        cur_i     = '0;
        cur_q     = '0;
        for (int unsigned n = 0; n < NCH; n++) begin
            if (rem_q[n] && !sel_found) begin
                sel_found = 1'b1;
                cur_ch    = 2'(n);
                cur_i     = hold_i_q[n*SW +: SW];
                cur_q     = hold_q_q[n*SW +: SW];
            end
        end
    end

    assign word  = {16'($signed(cur_q)), 16'($signed(cur_i))};
    assign level = wr_q - rd_q;
    assign full  = (level == LW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        ovf_d    = ovf_q;
        wr_d     = wr_q;
        rd_d     = rd_q;

        pop     = (level != '0) && stream.out_ready;
        push    = (state_q == S_BUSY) && sel_found && (!full || pop) && !sync_i;
        last_wr = push && ((rem_q & (rem_q - NCH'(1))) == '0);
        accept  = stream.in_valid && en_i && (chan_mask_i != '0) && gate && !sync_i;
        // A new set may load on the cycle the previous set's final word goes out.
        take    = accept && ((state_q == S_IDLE) || last_wr);
        drop    = accept && !take;

        if (sync_i) begin
            state_d = S_IDLE;
            rem_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            wr_d = wr_q + LW'(push);
            rd_d = rd_q + LW'(pop);
            if (take) begin
                state_d  = S_BUSY;
                rem_d    = chan_mask_i;
                hold_i_d = stream.in_i;
                hold_q_d = stream.in_q;
            end else if (last_wr) begin
                state_d = S_IDLE;
                rem_d   = '0;
            end else if (push) begin
                rem_d = rem_q & ~(NCH'(1) << cur_ch);
            end
        end

        if (ovf_clr_i)
            ovf_d = '0;
        else if (drop && (ovf_q != '1))
            ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            hold_i_q <= '0;
            hold_q_q <= '0;
            ovf_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= {cur_ch, word};
    end

    assign stream.out_valid = (level != '0);
    assign stream.out_data  = stream.out_valid ? mem_q[rd_q[AW-1:0]][31:0]  : '0;
    assign stream.out_chan  = stream.out_valid ? mem_q[rd_q[AW-1:0]][33:32] : '0;
    assign fifo_level_o     = level;
    assign ovf_cnt_o        = ovf_q;

`ifdef RX_PACK_TDD_GATE_EN
    logic [23:0] cnt_q, cnt_d;
    logic        open_q, open_d;

    // Window is evaluated on the next count so open_q matches cnt_q when sampled.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_i)
            cnt_d = '0;
        else if (stream.in_valid && en_i)
            cnt_d = (cnt_q == frame_len_i - 24'd1) ? '0 : cnt_q + 24'd1;

        if (rstart_i < rend_i)
            open_d = (cnt_d >= rstart_i) && (cnt_d < rend_i);
        else if (rstart_i > rend_i)
            open_d = (cnt_d >= rstart_i) || (cnt_d < rend_i);
        else
            open_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            open_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            open_q <= open_d;
        end
    end

    assign gate       = open_q;
    assign tdd_open_o = open_q;
`else
    logic unused_tdd;
    assign unused_tdd = ^{frame_len_i, rstart_i, rend_i};
    assign gate       = 1'b1;
    assign tdd_open_o = 1'b1;
`endif
endmodule
